video_stream_framer: RTL
========================

VIDEO_STREAM_FRAMER -- requirements
Module: video_stream_framer

Interface
REQ-001 Parameter: DIM_W, 12, bit width of the column and row count fields.
REQ-002 Parameter: PIX_W, 24, width of the raw input pixel word (at most 32).
REQ-003 Port: aclk  in  1  single clock; all logic on rising edge; one clock, reset is synchronous and active-high.
REQ-004 Port: areset  in  1  synchronous active-high reset.
REQ-005 Port: cfg_cols  in  DIM_W  pixels per line; sampled at start.
REQ-006 Port: cfg_rows  in  DIM_W  lines per frame; sampled at start.
REQ-007 Port: cfg_start  in  1  one-cycle pulse that arms one frame.
REQ-008 Port: s_pix_tvalid / s_pix_tready / s_pix_tdata  in/out/in  1/1/PIX_W  raw pixel handshake.
REQ-009 Port: OUTPUT_STREAM_TVALID/TREADY/TDATA/TKEEP/TSTRB/TUSER/TLAST/TID/TDEST  out/in/out...  1/1/32/4/4/1/1/1/1  AXI4-Stream video feeding the image filter INPUT_STREAM.
REQ-010 Port: busy  out  1  high while a frame is in progress.
REQ-011 Port: frame_done  out  1  one-cycle pulse after the last beat transfers.

Function
REQ-012 States SHALL be IDLE and ACTIVE; cfg_start in IDLE with both cfg_cols and cfg_rows nonzero latches both values, clears col/row counters, and enters ACTIVE next cycle.
REQ-013 cfg_start in IDLE with cfg_cols==0 or cfg_rows==0 SHALL be ignored; cfg_start in ACTIVE SHALL be ignored.
REQ-014 s_pix_tready SHALL be 0 in IDLE; in ACTIVE it SHALL equal (!OUTPUT_STREAM_TVALID || OUTPUT_STREAM_TREADY), and it SHALL be 0 once the final pixel of the frame has been accepted.
REQ-015 An accepted pixel SHALL appear on the output one cycle later (single register stage), giving full throughput of one beat per cycle with no bubbles.
REQ-016 TDATA SHALL be zero-extended s_pix_tdata; TKEEP=TSTRB=4'hF; TID=TDEST=0.
REQ-017 TUSER SHALL be 1 only on the beat at col 0, row 0; TLAST SHALL be 1 only on beats at col==cols-1.
REQ-018 col SHALL increment per accepted pixel and wrap to 0 after cols-1, incrementing row; row wraps to 0 after rows-1.
REQ-019 While TVALID=1 and TREADY=0, all output fields SHALL hold stable.
REQ-020 When the final beat (row rows-1, col cols-1) handshakes, the FSM SHALL return to IDLE, drop busy, and pulse frame_done in the following cycle.
REQ-021 busy SHALL rise the cycle after an accepted cfg_start; a new cfg_start is accepted on the first cycle busy is low.

Reset
REQ-022 areset SHALL force IDLE, counters=0, TVALID=0, TUSER=0, TLAST=0, TDATA=0, s_pix_tready=0, busy=0, frame_done=0, and clear latched dimensions, including mid-frame; a partial frame is dropped without a closing TLAST.

Configuration
REQ-023 With FRAMER_FRAME_CNT_EN defined, a 16-bit output frame_count SHALL increment (wrapping 0xFFFF->0) in the cycle frame_done pulses and reset to 0; without the macro, the port and counter SHALL be absent.

Structure
REQ-024 Package video_framer_pkg SHALL hold DIM_W default, the IDLE/ACTIVE state enum, and the TKEEP_ALL=4'hF constant.
REQ-025 The output register with hold-under-backpressure SHALL be sub-module axis_out_reg; counters and FSM live in the top.

Verification
REQ-026 cols=4, rows=2, input always valid, TREADY=1 -> 8 beats on consecutive cycles; TUSER on beat 0; TLAST on beats 3 and 7; frame_done one cycle after beat 7.
REQ-027 TREADY low for 3 cycles at beat 2 -> TDATA/TUSER/TLAST held stable, s_pix_tready=0 throughout, no beat lost or duplicated.
REQ-028 cfg_start with cols=0, and cfg_start while busy -> busy unchanged, no output beats, no latched-dimension change.
REQ-029 areset asserted after beat 5 of a 4x2 frame -> all outputs reset next cycle; a subsequent 2x1 frame yields TUSER on beat 0 and TLAST on beat 1.
REQ-030 With FRAMER_FRAME_CNT_EN, 3 back-to-back 1x1 frames -> frame_count reads 1, 2, 3; without it, the build elaborates with no frame_count port.

Source files
------------

// File: rtl/video_framer_pkg.sv
// Shared types and constants for the video stream framer.
// The FRAMER_FRAME_CNT_EN macro (top level) adds a 16-bit completed-frame counter.
package video_framer_pkg;

    localparam int         DIM_W_DEFAULT = 12;
    localparam logic [3:0] TKEEP_ALL     = 4'hF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // One output beat: payload plus the two per-beat framing flags.
    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream output register; contents hold while the sink stalls.
module axis_out_reg
    import video_framer_pkg::*;
(
    input  logic  aclk,
    input  logic  areset,
    input  logic  load,
    input  beat_t beat_in,
    input  logic  tready,
    output logic  tvalid,
    output beat_t beat_out,
    output logic  can_load
);

    // A new beat may enter when the register is empty or draining this cycle.
    assign can_load = !tvalid || tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid   <= 1'b0;
            beat_out <= '0;
        end else if (load) begin
            tvalid   <= 1'b1;
            beat_out <= beat_in;
        end else if (tready) begin
            tvalid   <= 1'b0;
        end
    end

endmodule

// File: rtl/video_stream_framer.sv
// Frames a raw pixel stream into AXI4-Stream video (TUSER = SOF, TLAST = EOL).
// Define FRAMER_FRAME_CNT_EN to add the frame_count output.
module video_stream_framer
    import video_framer_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEFAULT,
    parameter int PIX_W = 24
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic             cfg_start,
    input  logic             s_pix_tvalid,
    output logic             s_pix_tready,
    input  logic [PIX_W-1:0] s_pix_tdata,
    output logic             OUTPUT_STREAM_TVALID,
    input  logic             OUTPUT_STREAM_TREADY,
    output logic [31:0]      OUTPUT_STREAM_TDATA,
    output logic [3:0]       OUTPUT_STREAM_TKEEP,
    output logic [3:0]       OUTPUT_STREAM_TSTRB,
    output logic             OUTPUT_STREAM_TUSER,
    output logic             OUTPUT_STREAM_TLAST,
    output logic             OUTPUT_STREAM_TID,
    output logic             OUTPUT_STREAM_TDEST,
    output logic             busy,
    output logic             frame_done
`ifdef FRAMER_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] cols_q, rows_q, col_q, row_q;
    logic             pix_done_q;
    logic             start_ok, final_hs, accept, can_load, last_col, last_row;
    beat_t            beat_in, beat_out;

    assign last_col = (col_q == cols_q - ONE);
    assign last_row = (row_q == rows_q - ONE);
    assign accept   = s_pix_tvalid && s_pix_tready;

    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        s_pix_tready = 1'b0;
        start_ok     = 1'b0;
        final_hs     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start && cfg_cols != '0 && cfg_rows != '0) begin
                    start_ok = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                s_pix_tready = !pix_done_q && can_load;
                // Once every pixel is in, the output register holds the final beat.
                final_hs = pix_done_q && OUTPUT_STREAM_TVALID && OUTPUT_STREAM_TREADY;
                if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_done_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= final_hs;
            if (start_ok) begin
                cols_q     <= cfg_cols;
                rows_q     <= cfg_rows;
                col_q      <= '0;
                row_q      <= '0;
                pix_done_q <= 1'b0;
            end else if (accept) begin
                if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                        row_q      <= '0;
                        pix_done_q <= 1'b1;
                    end else begin
                        row_q <= row_q + ONE;
                    end
                end else begin
                    col_q <= col_q + ONE;
                end
            end
        end
    end

    assign beat_in.data = 32'(s_pix_tdata);
    assign beat_in.user = (col_q == '0) && (row_q == '0);
    assign beat_in.last = last_col;

    axis_out_reg u_out (
        .aclk     (aclk),
        .areset   (areset),
        .load     (accept),
        .beat_in  (beat_in),
        .tready   (OUTPUT_STREAM_TREADY),
        .tvalid   (OUTPUT_STREAM_TVALID),
        .beat_out (beat_out),
        .can_load (can_load)
    );

    assign OUTPUT_STREAM_TDATA = beat_out.data;
    assign OUTPUT_STREAM_TUSER = beat_out.user;
    assign OUTPUT_STREAM_TLAST = beat_out.last;
    assign OUTPUT_STREAM_TKEEP = TKEEP_ALL;
    assign OUTPUT_STREAM_TSTRB = TKEEP_ALL;
    assign OUTPUT_STREAM_TID   = 1'b0;
    assign OUTPUT_STREAM_TDEST = 1'b0;
    assign busy                = (state_q == ACTIVE);

`ifdef FRAMER_FRAME_CNT_EN
    // Advances on the same edge that raises frame_done, wrapping naturally.
    always_ff @(posedge aclk) begin
        if (areset)        frame_count <= '0;
        else if (final_hs) frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
